// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction prefetch front-end.
package ifetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Byte PC to IMEM word address, masked to the memory's address width.
  function automatic logic [31:0] word_addr(input logic [31:0] pc, input int addr_w);
    logic [31:0] mask;
    mask = (addr_w >= 30) ? 32'h3FFF_FFFF : ((32'h1 << addr_w) - 32'h1);
    return (pc >> 2) & mask;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];
  assign do_pop = pop & ~empty;

  // Storage survives a flush; only the pointers and count restart.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch front-end: IMEM request engine, redirect handling, output FIFO.
// Optional IFETCH_PERF_CNT_EN adds accepted-instruction and flush counters.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]       instr_pc,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`else
  output logic [31:0]       instr_pc
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             pop, fifo_pop, fifo_push;
  logic [CNT_W:0]   occupancy;
  fetch_entry_t     head, push_entry;

  assign instr_valid = ~fifo_empty;
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;
  assign pop         = instr_valid & instr_ready;
  assign fifo_pop    = pop & ~redirect_valid;
  assign fifo_push   = inflight_q & ~redirect_valid & (~fifo_full | fifo_pop);
  assign push_entry  = '{pc: req_pc_q, instr: imem_rdata};

  // Slots already committed (buffered plus in flight) after this cycle's pop.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign imem_req  = RSTn & ~redirect_valid & (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_addr = ADDR_W'(word_addr(fetch_pc_q, ADDR_W));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // A redirect only counts as a flush when it actually throws work away.
  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, fifo_pop};
    perf_flush_d = perf_flush_q;
    if (redirect_valid && ((fifo_count != '0) || inflight_q)) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Instruction fetch front-end that sits directly upstream of the single-cycle RV32I core's Instruction input.
- Drives a synchronous instruction memory (IMEM) with a fixed 1-cycle read latency.
- Buffers fetched words with their PC in a small FIFO.
- Presents them to the core through a valid/ready handshake.
- Restarts fetch at a new PC when the core signals a taken branch or jump (redirect).

Parameters:
DEPTH, 4, FIFO entries; power of two, ≥2.
ADDR_W, 10, IMEM word-address width (imem_addr = pc[ADDR_W+1:2]).
RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
CLK  in  1  clock
RSTn  in  1  reset, asynchronous, active-low
redirect_valid  in  1  core requests fetch restart this cycle
redirect_pc  in  32  restart address; bits [1:0] ignored
imem_req  out  1  IMEM read strobe
imem_addr  out  ADDR_W  IMEM word address
imem_rdata  in  32  IMEM read data, valid the cycle after imem_req
instr_valid  out  1  FIFO head valid
instr_ready  in  1  core accepts head
instr_data  out  32  head instruction word
instr_pc  out  32  head PC

Behaviour:
- Reset values (async, RSTn=0):
  - fetch_pc=RESET_PC; FIFO count=0, pointers=0, storage=0.
  - inflight=0; imem_req=0; instr_valid=0; instr_data=0; instr_pc=0.
- First imem_req is issued in the first cycle after RSTn deasserts.
- pop = instr_valid & instr_ready. The head advances on the clock edge.
- Request rule: imem_req = !redirect_valid & (count + inflight - pop < DEPTH).
  - imem_addr = fetch_pc[ADDR_W+1:2].
  - On req: fetch_pc += 4, wrapping at 2^32; imem_addr wraps naturally. inflight <= 1, otherwise 0.
  - Request PC is registered alongside inflight.
- Response: if inflight=1 and no redirect this cycle, {req_pc, imem_rdata} is pushed at the clock edge.
  - The pushed entry is visible on instr_* in the next cycle. There is no bypass.
- Throughput: one instruction per cycle sustained when the core is always ready (DEPTH≥2).
- Full: count+inflight==DEPTH with no pop means no request, fetch_pc holds, and no response is ever lost.
- Empty: instr_valid=0. instr_data/instr_pc hold the last head storage values; the core must not sample them.
- Redirect (cycle t):
  - FIFO flushed (count=0, pointers reset); a pop in the same cycle is ignored.
  - The in-flight response arriving at t+1 is discarded (inflight cleared at t).
  - fetch_pc <= {redirect_pc[31:2],2'b00}; no imem_req at t.
  - Sequence: imem_req at t+1 with the new address, push at end of t+2, instr_valid=1 at t+3 (3-cycle redirect penalty).
- Back-to-back redirects: each restarts the sequence; the last one wins.
- Reset mid-operation: all state is cleared immediately, with no output glitch beyond the reset values.

Optional Feature:
IFETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt increments on every pop.
  - perf_flush_cnt increments on every redirect_valid cycle that discards ≥1 FIFO entry or an in-flight response.
- Undefined: ports and counters are absent; core behaviour is identical.

Decomposition:
- Package ifetch_pkg:
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}.
  - INSTR_NOP = 32'h0000_0013.
  - Function word_addr(pc, ADDR_W).
- Sub-module ifetch_fifo:
  - Synchronous FIFO of fetch_entry_t with push, pop, and a flush taking priority over both.
  - Outputs count, full, empty.
- The top level holds fetch_pc, inflight, and the request/redirect logic.

Test Plan:
- Reset release, RESET_PC=0, instr_ready=1, IMEM[k]=k+0x100 -> imem_addr 0,1,2… on consecutive cycles; instr_valid first at cycle 2 with pc=0, data=0x100; then one per cycle.
- instr_ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_req=0 afterwards, no lost words; on release, pcs 0,4,8,C are delivered in order, then 0x10.
- Redirect to 0x40 while FIFO holds 3 entries and one is in flight -> flushed; imem_addr=0x10 next cycle; first delivered pc=0x40 three cycles after redirect; no stale pc appears.
- Redirect to 0x43 together with instr_ready=1 -> pop ignored, fetch restarts at 0x40.
- RSTn asserted mid-stream with FIFO non-empty -> instr_valid=0 at once; after release, fetch restarts at RESET_PC.
- With IFETCH_PERF_CNT_EN: 20 accepted instructions and 2 flushing redirects -> perf_fetch_cnt=20, perf_flush_cnt=2.
